// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_STATES cycles,
// commits the access on the edge entering RESP and holds the response until
// the consumer takes it. Storage is four byte-wide lane RAMs so stores need
// only per-lane write enables and loads use a registered read.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);
  localparam logic [29:0] BASE_W30  = BASE_ADDR[31:2];
  localparam logic [3:0]  CNT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, stateNext;
  logic               rstDone;
  logic [3:0]         waitCnt;
  logic               capWe;
  logic [1:0]         capSize;
  logic               capUnsigned;
  logic [31:0]        capAddr;
  logic [31:0]        capWdata;
  logic               rspErrReg;
  logic               loadOkReg;

  logic               reqReady;
  logic               accept;
  logic               commit;
  logic               opWe;
  logic [1:0]         opSize;
  logic [31:0]        opAddr;
  logic [31:0]        opWdata;
  logic [29:0]        offWord;
  logic [IDX_W-1:0]   opIdx;
  logic               outOfRange;
  logic               misaligned;
  logic               opErr;
  logic               laneWrite;
  logic               laneRead;
  logic [31:0]        rawWord;
  logic [7:0]         byteSel;
  logic [15:0]        halfSel;
  logic [31:0]        loadExt;

  // rstDone keeps req_ready low during reset and for the first edge after it
  assign reqReady = (state == IDLE) && rstDone;
  assign accept   = bus.req_valid && reqReady;
  // Commit happens exactly on the edge that moves the FSM into RESP
  assign commit   = (stateNext == RESP) && (state != RESP);

  assign bus.req_ready = reqReady;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = rspErrReg;
  assign bus.rsp_rdata = loadOkReg ? loadExt : 32'd0;

  // State register and post-reset ready qualifier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rstDone <= 1'b0;
    end else begin
      state   <= stateNext;
      rstDone <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (waitCnt == 4'd0) stateNext = RESP;
      RESP:    if (bus.rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Wait-state down-counter, loaded on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= 4'd0;
    end else if (accept) begin
      waitCnt <= CNT_LOAD;
    end else if (state == WAIT && waitCnt != 4'd0) begin
      waitCnt <= waitCnt - 4'd1;
    end
  end

  // Capture the request fields on accept; they stay valid through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capWe       <= 1'b0;
      capSize     <= 2'd0;
      capUnsigned <= 1'b0;
      capAddr     <= 32'd0;
      capWdata    <= 32'd0;
    end else if (accept) begin
      capWe       <= bus.req_we;
      capSize     <= bus.req_size;
      capUnsigned <= bus.req_unsigned;
      capAddr     <= bus.req_addr;
      capWdata    <= bus.req_wdata;
    end
  end

  // With zero wait states the commit edge is the accept edge, so the live
  // request fields are used from IDLE and the captured ones otherwise.
  assign opWe    = (state == IDLE) ? bus.req_we    : capWe;
  assign opSize  = (state == IDLE) ? bus.req_size  : capSize;
  assign opAddr  = (state == IDLE) ? bus.req_addr  : capAddr;
  assign opWdata = (state == IDLE) ? bus.req_wdata : capWdata;

  // Word-granular range check; an address below BASE_ADDR wraps and is rejected
  assign offWord    = opAddr[31:2] - BASE_W30;
  assign outOfRange = (opAddr[31:2] < BASE_W30) || (offWord >= DEPTH_W30);
  assign opIdx      = offWord[IDX_W-1:0];
  assign misaligned = ((opSize == 2'b01) && opAddr[0]) ||
                      ((opSize == 2'b10) && (opAddr[1:0] != 2'b00));
  assign opErr      = outOfRange || misaligned || (opSize == 2'b11);
  assign laneWrite  = commit && opWe && !opErr;
  assign laneRead   = commit && !opWe && !opErr;

  // Response flags latched at commit and held until the next commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rspErrReg <= 1'b0;
      loadOkReg <= 1'b0;
    end else if (commit) begin
      rspErrReg <= opErr;
      loadOkReg <= !opWe && !opErr;
    end
  end

  // One byte-wide RAM per lane with its own write enable and registered read
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] laneMem [DEPTH_WORDS];
      logic [7:0] rdByte;
      logic [7:0] wrByte;
      logic       laneHit;

      assign laneHit = (opSize == 2'b00) ? (opAddr[1:0] == 2'(gi)) :
                       (opSize == 2'b01) ? (opAddr[1] == 1'(gi / 2)) : 1'b1;
      assign wrByte  = (opSize == 2'b10) ? opWdata[8*gi +: 8] :
                       (opSize == 2'b01) ? opWdata[8*(gi%2) +: 8] : opWdata[7:0];

      // Lane write on store commit, lane read on load commit
      always_ff @(posedge clk) begin
        if (laneWrite && laneHit) laneMem[opIdx] <= wrByte;
        if (laneRead) rdByte <= laneMem[opIdx];
      end

      assign rawWord[8*gi +: 8] = rdByte;
    end
  endgenerate

  // Lane select and sign/zero extension of the read word
  always_comb begin
    byteSel = rawWord[{capAddr[1:0], 3'b000} +: 8];
    halfSel = capAddr[1] ? rawWord[31:16] : rawWord[15:0];
    loadExt = rawWord;
    case (capSize)
      2'b00:   loadExt = capUnsigned ? {24'd0, byteSel} : {{24{byteSel[7]}}, byteSel};
      2'b01:   loadExt = capUnsigned ? {16'd0, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: loadExt = rawWord;
    endcase
  end

endmodule
